lcd_pattern_gen: RTL and testbench

Pixel source feeding the RGB LCD timing driver: consumes the driver's `pixel_xpos`/`pixel_ypos` request coordinates and returns registered RGB565 `pixel_data` one cycle later, aligned with the driver's `lcd_de` window. It provides four selectable test patterns: colour bars, grid, gradient and a bouncing box. A debounced push-button cycles the pattern. Mode changes and box motion are applied only at frame boundaries, so no tearing occurs.

---
 rtl/lcd_pkg.sv | 51 +++++
 rtl/lcd_pattern_gen_if.sv | 11 +
 rtl/key_debounce.sv | 42 ++++
 rtl/lcd_pattern_gen.sv | 102 ++++++++++
 tb/tb_lcd_pattern_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD test-pattern source.
package lcd_pkg;

  localparam int unsigned H_DISP  = 800;
  localparam int unsigned V_DISP  = 480;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 16;

  typedef logic [RGB_W-1:0]   rgb565_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam rgb565_t WHITE   = 16'hFFFF;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t MAGENTA = 16'hF81F;
  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t BLUE    = 16'h001F;
  localparam rgb565_t BLACK   = 16'h0000;

  typedef enum logic [1:0] {BARS, GRID, GRAD, BOX} mode_e;
  typedef enum logic {DIR_POS, DIR_NEG} dir_e;

  typedef struct packed {
    coord_t pos;
    dir_e   dir;
  } axis_t;

  // One frame of bouncing motion along a single axis, clamped to [0, lim].
  function automatic axis_t axis_next(axis_t a, coord_t lim, coord_t step);
    axis_t r;
    r = a;
    if (a.dir == DIR_POS) begin
      if (({1'b0, a.pos} + {1'b0, step}) >= {1'b0, lim}) begin
        r.pos = lim;
        r.dir = DIR_NEG;
      end else begin
        r.pos = a.pos + step;
      end
    end else begin
      if (a.pos <= step) begin
        r.pos = '0;
        r.dir = DIR_POS;
      end else begin
        r.pos = a.pos - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Pixel request/response link between the LCD timing driver and a pixel source.
interface lcd_pix_if;
  import lcd_pkg::*;

  coord_t  pixel_xpos;
  coord_t  pixel_ypos;
  rgb565_t pixel_data;

  modport master (output pixel_xpos, output pixel_ypos, input  pixel_data);
  modport slave  (input  pixel_xpos, input  pixel_ypos, output pixel_data);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter; pulses press on each debounced 1->0.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 660000
) (
  input  logic lcd_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync2;
        press  <= ~sync2;
      end else begin
        cnt <= CW'(cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source: bars, grid, gradient and bouncing box, switched at frame end.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int unsigned BOX_SIZE     = 64,
  parameter int unsigned BOX_STEP     = 2,
  parameter int unsigned DEBOUNCE_CYC = 660000
) (
  input  logic       lcd_clk,
  input  logic       sys_rst_n,
  input  logic       key_n,
  lcd_pix_if.slave   pix,
  output logic [1:0] mode,
  output logic       frame_tick
);

  localparam coord_t X_LIM = COORD_W'(H_DISP - BOX_SIZE);
  localparam coord_t Y_LIM = COORD_W'(V_DISP - BOX_SIZE);
  localparam coord_t STEP  = COORD_W'(BOX_STEP);
  localparam logic [COORD_W:0] BOX_EXT = (COORD_W+1)'(BOX_SIZE);

  coord_t  xm1, ym1;
  logic    req, frame_last, press, in_box;
  rgb565_t bar_colour, pix_next;
  axis_t   bx_q, by_q, bx_n, by_n;
  mode_e   mode_q, mode_n;
  logic    pend_q, pend_n;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
    .lcd_clk   (lcd_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (key_n),
    .press     (press)
  );

  assign xm1        = pix.pixel_xpos - 11'd1;
  assign ym1        = pix.pixel_ypos - 11'd1;
  assign req        = (pix.pixel_xpos != '0) && (pix.pixel_ypos != '0);
  assign frame_last = (pix.pixel_xpos == COORD_W'(H_DISP)) && (pix.pixel_ypos == COORD_W'(V_DISP));

  assign in_box = ({1'b0, xm1} >= {1'b0, bx_q.pos}) && ({1'b0, xm1} < ({1'b0, bx_q.pos} + BOX_EXT)) &&
                  ({1'b0, ym1} >= {1'b0, by_q.pos}) && ({1'b0, ym1} < ({1'b0, by_q.pos} + BOX_EXT));

  // Bar colour by threshold compare on the column
  always_comb begin
    bar_colour = BLACK;
    if      (xm1 < 11'd100) bar_colour = WHITE;
    else if (xm1 < 11'd200) bar_colour = YELLOW;
    else if (xm1 < 11'd300) bar_colour = CYAN;
    else if (xm1 < 11'd400) bar_colour = GREEN;
    else if (xm1 < 11'd500) bar_colour = MAGENTA;
    else if (xm1 < 11'd600) bar_colour = RED;
    else if (xm1 < 11'd700) bar_colour = BLUE;
  end

  always_comb begin
    pix_next = BLACK;
    if (req) begin
      case (mode_q)
        BARS: pix_next = bar_colour;
        GRID: pix_next = ((xm1[4:0] == 5'd0) || (ym1[4:0] == 5'd0)) ? WHITE : BLACK;
        GRAD: pix_next = {xm1[9:5], ym1[8:3], 5'd16};
        BOX:  pix_next = in_box ? GREEN : BLACK;
        default: pix_next = BLACK;
      endcase
    end
  end

  // Box motion and mode advance only on the frame's last pixel; a press on that edge waits a frame
  always_comb begin
    bx_n   = bx_q;
    by_n   = by_q;
    mode_n = mode_q;
    pend_n = press | (pend_q & ~frame_last);
    if (frame_last) begin
      bx_n = axis_next(bx_q, X_LIM, STEP);
      by_n = axis_next(by_q, Y_LIM, STEP);
      if (pend_q) mode_n = mode_e'(2'(mode_q + 2'd1));
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bx_q           <= '{pos: '0, dir: DIR_POS};
      by_q           <= '{pos: '0, dir: DIR_POS};
      mode_q         <= BARS;
      pend_q         <= 1'b0;
      frame_tick     <= 1'b0;
      pix.pixel_data <= BLACK;
    end else begin
      bx_q           <= bx_n;
      by_q           <= by_n;
      mode_q         <= mode_n;
      pend_q         <= pend_n;
      frame_tick     <= frame_last;
      pix.pixel_data <= pix_next;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed + randomized bench for lcd_pattern_gen against a frame-level behavioural model.
module tb_lcd_pattern_gen;

  localparam int DEB = 16;

  logic       lcd_clk;
  logic       sys_rst_n;
  logic       key_n;
  logic [1:0] mode;
  logic       frame_tick;

  lcd_pix_if pix ();

  lcd_pattern_gen #(.BOX_SIZE(64), .BOX_STEP(2), .DEBOUNCE_CYC(DEB)) dut (
    .lcd_clk    (lcd_clk),
    .sys_rst_n  (sys_rst_n),
    .key_n      (key_n),
    .pix        (pix),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  initial lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  int n_assert;
  int n_fail;

  // Reference model state
  int m_mode, m_bx, m_by, m_dx, m_dy;
  bit m_pend, m_press;
  bit m_k1, m_k2, m_stable;
  int m_run;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic model_reset();
    m_mode = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_pend = 0; m_press = 0; m_k1 = 1; m_k2 = 1; m_stable = 1; m_run = 0;
  endtask

  function automatic logic [15:0] ref_pix(int x, int y);
    int xm, ym;
    if (x == 0 || y == 0) return 16'h0000;
    xm = x - 1;
    ym = y - 1;
    case (m_mode)
      0: return bars[xm / 100];
      1: return ((xm % 32 == 0) || (ym % 32 == 0)) ? 16'hFFFF : 16'h0000;
      2: return 16'((((xm / 32) % 32) << 11) | (((ym / 8) % 64) << 5) | 16);
      default: return (xm >= m_bx && xm < m_bx + 64 && ym >= m_by && ym < m_by + 64) ? 16'h07E0 : 16'h0000;
    endcase
  endfunction

  task automatic move_axis(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + 2 >= lim) begin p = lim; d = -1; end else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; d = 1; end else p = p - 2;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive request and key, update model at the edge, compare just after it
  task automatic step(input int x, input int y, input bit k);
    logic [15:0] e_pix;
    bit fl, lvl, prs;
    pix.pixel_xpos = 11'(x);
    pix.pixel_ypos = 11'(y);
    key_n = k;
    @(posedge lcd_clk);
    e_pix = ref_pix(x, y);
    fl    = (x == 800 && y == 480);
    lvl   = m_k2;
    m_k2  = m_k1;
    m_k1  = k;
    prs   = 0;
    if (lvl != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = lvl;
        m_run    = 0;
        prs      = !lvl;
      end
    end else begin
      m_run = 0;
    end
    if (fl) begin
      if (m_pend) m_mode = (m_mode + 1) % 4;
      move_axis(m_bx, m_dx, 736);
      move_axis(m_by, m_dy, 416);
    end
    m_pend  = m_press | (m_pend && !fl);
    m_press = prs;
    #1;
    chk("pixel", pix.pixel_data, e_pix);
    chk("mode", 16'(mode), 16'(m_mode));
    chk("tick", 16'(frame_tick), fl ? 16'd1 : 16'd0);
  endtask

  task automatic press_key();
    repeat (30) step(0, 0, 0);
    repeat (30) step(0, 0, 1);
  endtask

  initial begin
    int saved, x, y;
    n_assert = 0;
    n_fail   = 0;
    sys_rst_n = 1'b0;
    key_n     = 1'b1;
    pix.pixel_xpos = '0;
    pix.pixel_ypos = '0;
    model_reset();
    repeat (3) @(posedge lcd_clk);
    #1;
    chk("rst_pixel", pix.pixel_data, 16'h0000);
    chk("rst_mode", 16'(mode), 16'd0);
    chk("rst_tick", 16'(frame_tick), 16'd0);
    sys_rst_n = 1'b1;

    // Colour bars across the first line
    for (int i = 1; i <= 800; i++) begin
      step(i, 1, 1);
      if (i == 100) chk("bar_100", pix.pixel_data, 16'hFFFF);
      if (i == 101) chk("bar_101", pix.pixel_data, 16'hFFE0);
      if (i == 701) chk("bar_701", pix.pixel_data, 16'h0000);
    end
    step(0, 5, 1);
    chk("blank_0_5", pix.pixel_data, 16'h0000);

    // Short glitch is ignored; a long press advances only at frame end
    repeat (10) step(0, 0, 0);
    repeat (40) step(0, 0, 1);
    step(800, 480, 1);
    chk("glitch_mode", 16'(mode), 16'd0);
    press_key();
    chk("pend_mode", 16'(mode), 16'd0);
    step(800, 480, 1);
    chk("press_mode", 16'(mode), 16'd1);

    // Two presses inside one frame advance once
    press_key();
    press_key();
    step(800, 480, 1);
    chk("double_press", 16'(mode), 16'd2);

    // Gradient under random coordinates
    repeat (1500) step($urandom_range(0, 800), $urandom_range(0, 480), 1);

    // Box mode, coordinates biased around the box edges
    press_key();
    step(800, 480, 1);
    chk("box_mode", 16'(mode), 16'd3);
    for (int i = 0; i < 1500; i++) begin
      x = m_bx + int'($urandom_range(0, 66));
      y = m_by + int'($urandom_range(0, 66));
      if (x > 800) x = 800;
      if (y > 480) y = 480;
      if ($urandom_range(0, 99) == 0) begin x = 800; y = 480; end
      step(x, y, 1);
    end

    // Press lands on the same edge as frame_last: deferred one frame
    repeat (20) step(0, 0, 1);
    saved = m_mode;
    repeat (2 + DEB) step(0, 0, 0);
    step(800, 480, 0);
    chk("same_edge_hold", 16'(mode), 16'(saved));
    chk("tick_hi", 16'(frame_tick), 16'd1);
    step(0, 0, 1);
    chk("tick_lo", 16'(frame_tick), 16'd0);
    repeat (20) step(0, 0, 1);
    step(800, 480, 1);
    chk("same_edge_next", 16'(mode), 16'((saved + 1) % 4));

    // Reach mode 2 with the box displaced, then reset mid-line
    while (m_mode != 2) begin
      press_key();
      step(800, 480, 1);
    end
    for (int i = 1; i <= 50; i++) step(i, 10, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_pixel", pix.pixel_data, 16'h0000);
    chk("midrst_mode", 16'(mode), 16'd0);
    chk("midrst_tick", 16'(frame_tick), 16'd0);
    model_reset();
    @(posedge lcd_clk);
    #1;
    sys_rst_n = 1'b1;
    step(1, 1, 1);
    chk("post_rst_bar", pix.pixel_data, 16'hFFFF);

    // From reset, 368 frame ends take the box to the right limit
    repeat (3) begin
      press_key();
      step(800, 480, 1);
    end
    chk("box_mode2", 16'(mode), 16'd3);
    step(7, 7, 1);
    chk("box_6_in", pix.pixel_data, 16'h07E0);
    step(6, 7, 1);
    chk("box_6_out", pix.pixel_data, 16'h0000);
    repeat (365) step(800, 480, 1);
    step(737, m_by + 1, 1);
    chk("box_736_in", pix.pixel_data, 16'h07E0);
    step(736, m_by + 1, 1);
    chk("box_736_out", pix.pixel_data, 16'h0000);
    step(800, 480, 1);
    step(735, m_by + 1, 1);
    chk("box_734_in", pix.pixel_data, 16'h07E0);
    step(734, m_by + 1, 1);
    chk("box_734_out", pix.pixel_data, 16'h0000);
    step(737, 1, 1);
    step(800, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
